reg_window_decode: RTL and testbench
====================================

# reg_window_decode

Parametrised register-window address decoder for the R.O.E datapath. It holds a page (window) register and concatenates it with the short register fields of each instruction to form full register-file addresses for one source and one destination. It supports sticky and one-shot page selection, delays the destination address to the writeback stage, and flags read-after-write hazards against in-flight writes. It sits between instruction fetch/decode and the register file.

## Interface
Parameters:
- PAGE_W, 2, page (window) register width
- FIELD_W, 2, width of instruction register fields; ADDR_W = PAGE_W + FIELD_W
- WB_DELAY, 2, cycles from decode output to writeback (range 1..8)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- instr_valid  in  1  instruction present this cycle
- set_page  in  1  instruction carries a page select (qualified by instr_valid)
- page_mode  in  1  0 = sticky, 1 = one-shot (qualified by set_page)
- page_in  in  PAGE_W  page value carried by the instruction
- rs_field  in  FIELD_W  source register field
- rd_field  in  FIELD_W  destination register field
- rd_we  in  1  instruction writes rd
- rs_addr  out  ADDR_W  registered source address
- rd_addr  out  ADDR_W  registered destination address
- dec_valid  out  1  rs_addr/rd_addr valid
- page_q  out  PAGE_W  current sticky page
- wb_addr  out  ADDR_W  destination address delayed to writeback
- wb_we  out  1  writeback write enable, delayed with wb_addr
- raw_hazard  out  1  registered; rs_addr matches a pending write

## Operation
- Effective page eff = (instr_valid & set_page) ? page_in : page_q.
- The new page applies to the same instruction that carries it.
- Sticky (page_mode=0): page_q <= page_in on that edge.
- One-shot (page_mode=1): page_q unchanged; eff used for this instruction only.
- Each edge with instr_valid=1: rs_addr <= {eff, rs_field}, rd_addr <= {eff, rd_field}, dec_valid <= 1.
- Each edge with instr_valid=0: dec_valid <= 0; rs_addr/rd_addr hold.
- Delay line: WB_DELAY stages of {addr, we}. Stage 0 loads {rd_addr, dec_valid & rd_we_q}; the output of the last stage drives wb_addr/wb_we. rd_we_q is rd_we registered with the decode.
- raw_hazard <= instr_valid & OR over all pending entries (the decode output stage plus delay stages 0..WB_DELAY-2) of (we & addr == {eff, rs_field}). The final stage is excluded because it writes back in the same cycle and the register file forwards.
- raw_hazard is advisory only. The block never stalls; the issuing control is responsible for acting on it.

## Timing
- Reset asserted: all outputs 0, page_q = 0, all delay stages cleared, asynchronously.
- Reset deasserted mid-stream: the first instruction sees page 0 and no hazards.
- Decode latency 1 cycle; writeback latency 1 + WB_DELAY cycles from instr_valid.
- Delay line is free-running: it advances every cycle and bubbles propagate with we = 0.
- Two consecutive set_page instructions: each uses its own page_in. A one-shot following a sticky instruction reverts to the sticky value on the next instruction.
- set_page with instr_valid=0 is ignored.
- Address arithmetic is concatenation only; there is no wrap-around or carry.

## Structure
- Package roe_regdec_pkg:
  - page_mode_e enum {PAGE_STICKY, PAGE_ONESHOT}
  - wb_entry_t struct {addr, we}, parametrised via ADDR_W localparam defaults
- Sub-module wb_delay_line: parametrised shift register of wb_entry_t with async reset. It exposes all stage contents for the hazard compare.

## Test plan
- Reset then instr_valid, rs=1, rd=2, no set_page -> next cycle rs_addr=4'h1, rd_addr=4'h2, page_q=0.
- Sticky set_page page_in=3, rs=1, then plain instr rs=2 -> rs_addr=4'hD then 4'hE; page_q=3.
- One-shot page_in=2, rs=0, after sticky page 1 -> rs_addr=4'h8, next plain instr rs=0 -> 4'h4; page_q stays 1.
- rd=3 with rd_we, page 0, WB_DELAY=2 -> wb_addr=4'h3, wb_we=1 exactly 3 cycles later; the next instr with rs=3 gives raw_hazard=1; rd_we=0 gives raw_hazard=0.
- Reset asserted mid-stream with pending writes -> wb_we=0, page_q=0 immediately, no spurious writeback after release.
- PAGE_W=3, FIELD_W=3, WB_DELAY=4 sweep of random instructions -> matches a scoreboard model on every cycle.

Source files
------------

// File: rtl/roe_regdec_pkg.sv
// Shared types for the R.O.E register-window decoder.
//   page_mode_e : how a page select carried by an instruction is applied
//   wb_entry_t  : one writeback delay-line slot {addr, we} at default widths;
//                 instances with other widths pass their own entry type to
//                 wb_delay_line through its type parameter.
package roe_regdec_pkg;

  localparam int unsigned PAGE_W_DEF  = 2;
  localparam int unsigned FIELD_W_DEF = 2;
  localparam int unsigned ADDR_W      = PAGE_W_DEF + FIELD_W_DEF;

  typedef enum logic {
    PAGE_STICKY  = 1'b0,
    PAGE_ONESHOT = 1'b1
  } page_mode_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
  } wb_entry_t;

endpackage

// File: rtl/wb_delay_line.sv
// Free-running shift register carrying destination writes to writeback.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous active-high reset, clears every stage
//   din    : entry loaded into stage 0 each cycle
//   stages : contents of all stages, stage DEPTH-1 is the writeback output
module wb_delay_line
  import roe_regdec_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter type         entry_t = wb_entry_t
) (
  input  logic   clk,
  input  logic   reset,
  input  entry_t din,
  output entry_t stages [DEPTH]
);

  entry_t stage_q [DEPTH];

  // Advances every cycle; bubbles travel with we = 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < int'(DEPTH); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign stages = stage_q;

endmodule

// File: rtl/reg_window_decode.sv
// Register-window address decoder: prefixes short instruction register fields
// with a page (window) value to form full register-file addresses, delays the
// destination to writeback and flags read-after-write hazards (advisory only).
// Ports:
//   clk, reset            : clock (rising edge), async active-high reset
//   instr_valid           : instruction present this cycle
//   set_page, page_mode   : page select and its mode (0 sticky, 1 one-shot)
//   page_in               : page value carried by the instruction
//   rs_field, rd_field    : short source / destination register fields
//   rd_we                 : instruction writes rd
//   rs_addr, rd_addr      : registered full addresses, qualified by dec_valid
//   page_q                : current sticky page
//   wb_addr, wb_we        : destination write delayed to writeback
//   raw_hazard            : registered; source matches an in-flight write
module reg_window_decode
  import roe_regdec_pkg::*;
#(
  parameter int unsigned PAGE_W   = 2,
  parameter int unsigned FIELD_W  = 2,
  parameter int unsigned WB_DELAY = 2  // 1..8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      instr_valid,
  input  logic                      set_page,
  input  logic                      page_mode,
  input  logic [PAGE_W-1:0]         page_in,
  input  logic [FIELD_W-1:0]        rs_field,
  input  logic [FIELD_W-1:0]        rd_field,
  input  logic                      rd_we,
  output logic [PAGE_W+FIELD_W-1:0] rs_addr,
  output logic [PAGE_W+FIELD_W-1:0] rd_addr,
  output logic                      dec_valid,
  output logic [PAGE_W-1:0]         page_q,
  output logic [PAGE_W+FIELD_W-1:0] wb_addr,
  output logic                      wb_we,
  output logic                      raw_hazard
);

  localparam int unsigned AddrW = PAGE_W + FIELD_W;

  typedef struct packed {
    logic [AddrW-1:0] addr;
    logic             we;
  } entry_t;

  logic              take_page;
  logic [PAGE_W-1:0] eff_page;
  logic [PAGE_W-1:0] page_d;
  logic [AddrW-1:0]  rs_full;
  logic [AddrW-1:0]  rd_full;
  logic              rd_we_q;
  logic              hazard_d;
  entry_t            stage_in;
  entry_t            stages [WB_DELAY];

  // The carried page applies to its own instruction; only sticky selects
  // update the page register.
  always_comb begin
    take_page = instr_valid & set_page;
    eff_page  = take_page ? page_in : page_q;
    page_d    = page_q;
    if (take_page && (page_mode_e'(page_mode) == PAGE_STICKY)) begin
      page_d = page_in;
    end
    rs_full = {eff_page, rs_field};
    rd_full = {eff_page, rd_field};
  end

  // Pending writes: the decode output plus every delay stage except the last,
  // which writes back this cycle and is forwarded by the register file.
  always_comb begin
    hazard_d = dec_valid & rd_we_q & (rd_addr == rs_full);
    for (int i = 0; i < int'(WB_DELAY) - 1; i++) begin
      hazard_d = hazard_d | (stages[i].we & (stages[i].addr == rs_full));
    end
    hazard_d = hazard_d & instr_valid;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      page_q     <= '0;
      rs_addr    <= '0;
      rd_addr    <= '0;
      rd_we_q    <= 1'b0;
      dec_valid  <= 1'b0;
      raw_hazard <= 1'b0;
    end else begin
      page_q     <= page_d;
      dec_valid  <= instr_valid;
      raw_hazard <= hazard_d;
      if (instr_valid) begin
        rs_addr <= rs_full;
        rd_addr <= rd_full;
        rd_we_q <= rd_we;
      end
    end
  end

  always_comb begin
    stage_in.addr = rd_addr;
    stage_in.we   = dec_valid & rd_we_q;
  end

  wb_delay_line #(
    .DEPTH   (WB_DELAY),
    .entry_t (entry_t)
  ) u_wb_delay_line (
    .clk    (clk),
    .reset  (reset),
    .din    (stage_in),
    .stages (stages)
  );

  assign wb_addr = stages[WB_DELAY-1].addr;
  assign wb_we   = stages[WB_DELAY-1].we;

endmodule

// File: tb/tb_reg_window_decode.sv
// Two instances share stimulus: A (page 2, field 2, delay 2) and
// B (page 3, field 3, delay 4). A queue-based reference model predicts
// decode and writeback responses; a monitor pops and compares them.
module tb_reg_window_decode;

  logic       clk = 1'b0;
  logic       reset;
  logic       instr_valid, set_page, page_mode, rd_we;
  logic [2:0] page_in, rs_field, rd_field;

  logic [3:0] a_rs, a_rd, a_wb;
  logic [1:0] a_pg;
  logic       a_dv, a_we, a_hz;
  logic [5:0] b_rs, b_rd, b_wb;
  logic [2:0] b_pg;
  logic       b_dv, b_we, b_hz;

  reg_window_decode #(.PAGE_W(2), .FIELD_W(2), .WB_DELAY(2)) dut_a (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .set_page(set_page),
    .page_mode(page_mode), .page_in(page_in[1:0]), .rs_field(rs_field[1:0]),
    .rd_field(rd_field[1:0]), .rd_we(rd_we), .rs_addr(a_rs), .rd_addr(a_rd),
    .dec_valid(a_dv), .page_q(a_pg), .wb_addr(a_wb), .wb_we(a_we), .raw_hazard(a_hz)
  );

  reg_window_decode #(.PAGE_W(3), .FIELD_W(3), .WB_DELAY(4)) dut_b (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .set_page(set_page),
    .page_mode(page_mode), .page_in(page_in), .rs_field(rs_field),
    .rd_field(rd_field), .rd_we(rd_we), .rs_addr(b_rs), .rd_addr(b_rd),
    .dec_valid(b_dv), .page_q(b_pg), .wb_addr(b_wb), .wb_we(b_we), .raw_hazard(b_hz)
  );

  always #5 clk = ~clk;

  typedef struct {int rs; int rd; int hz; int pg;} dec_t;
  typedef struct {int addr; int at;} wb_t;
  typedef struct {int dut; int addr; int at;} fl_t;

  dec_t dq_a[$], dq_b[$];
  wb_t  wq_a[$], wq_b[$];
  fl_t  inflight[$];
  int   page_m[2];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always @(posedge clk) cyc++;

  function automatic int pw_of(int d); return (d == 0) ? 2 : 3; endfunction
  function automatic int fw_of(int d); return (d == 0) ? 2 : 3; endfunction
  function automatic int dl_of(int d); return (d == 0) ? 2 : 4; endfunction

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(string name, int act, int exp);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: an instruction latched at edge e sees page rules, forms
  // addresses as page * 2^field_w + field, and collides with any write issued
  // 1..delay edges earlier. Its write appears at writeback after edge e+delay.
  task automatic model_step(bit v, bit s, bit m, int pg, int rs, int rd, bit we, int e);
    for (int d = 0; d < 2; d++) begin
      int   fmask;
      int   pmask;
      int   eff;
      dec_t x;
      wb_t  w;
      fl_t  f;
      fmask = (1 << fw_of(d)) - 1;
      pmask = (1 << pw_of(d)) - 1;
      eff   = (v && s) ? (pg & pmask) : page_m[d];
      if (v && s && !m) page_m[d] = pg & pmask;
      if (v) begin
        x.rs = eff * (1 << fw_of(d)) + (rs & fmask);
        x.rd = eff * (1 << fw_of(d)) + (rd & fmask);
        x.pg = page_m[d];
        x.hz = 0;
        foreach (inflight[i]) begin
          if (inflight[i].dut == d && (e - inflight[i].at) >= 1 &&
              (e - inflight[i].at) <= dl_of(d) && inflight[i].addr == x.rs) x.hz = 1;
        end
        if (d == 0) dq_a.push_back(x); else dq_b.push_back(x);
        if (we) begin
          w.addr = x.rd;
          w.at   = e + dl_of(d);
          if (d == 0) wq_a.push_back(w); else wq_b.push_back(w);
          f.dut = d; f.addr = x.rd; f.at = e;
          inflight.push_back(f);
        end
      end
    end
  endtask

  task automatic drive(bit v, bit s, bit m, int pg, int rs, int rd, bit we);
    @(negedge clk);
    instr_valid = v;
    set_page    = s;
    page_mode   = m;
    page_in     = pg[2:0];
    rs_field    = rs[2:0];
    rd_field    = rd[2:0];
    rd_we       = we;
    model_step(v, s, m, pg, rs, rd, we, cyc + 1);
  endtask

  task automatic mon(int d, int rs, int rd, logic dv, logic hz, int pg, int wa, logic we);
    dec_t x;
    wb_t  w;
    string p;
    p = (d == 0) ? "a" : "b";
    if (dv) begin
      if ((d == 0 ? dq_a.size() : dq_b.size()) == 0) begin
        flag({p, "_dec_unexpected"}, 1, 0);
      end else begin
        x = (d == 0) ? dq_a.pop_front() : dq_b.pop_front();
        chk({p, "_rs_addr"}, rs, x.rs);
        chk({p, "_rd_addr"}, rd, x.rd);
        chk({p, "_raw_hazard"}, int'(hz), x.hz);
        chk({p, "_page_q"}, pg, x.pg);
      end
    end else begin
      chk({p, "_hazard_idle"}, int'(hz), 0);
    end
    if (d == 0) begin
      if (wq_a.size() > 0 && wq_a[0].at < cyc) begin
        flag("a_wb_missing", 0, 1);
        void'(wq_a.pop_front());
      end
    end else begin
      if (wq_b.size() > 0 && wq_b[0].at < cyc) begin
        flag("b_wb_missing", 0, 1);
        void'(wq_b.pop_front());
      end
    end
    if (we) begin
      if ((d == 0 ? wq_a.size() : wq_b.size()) == 0) begin
        flag({p, "_wb_spurious"}, 1, 0);
      end else begin
        w = (d == 0) ? wq_a.pop_front() : wq_b.pop_front();
        chk({p, "_wb_addr"}, wa, w.addr);
        chk({p, "_wb_cycle"}, cyc, w.at);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      mon(0, int'(a_rs), int'(a_rd), a_dv, a_hz, int'(a_pg), int'(a_wb), a_we);
      mon(1, int'(b_rs), int'(b_rd), b_dv, b_hz, int'(b_pg), int'(b_wb), b_we);
    end
  end

  task automatic reset_checks(string tag);
    chk({tag, "_a_dec_valid"}, int'(a_dv), 0);
    chk({tag, "_a_wb_we"}, int'(a_we), 0);
    chk({tag, "_a_page_q"}, int'(a_pg), 0);
    chk({tag, "_a_raw_hazard"}, int'(a_hz), 0);
    chk({tag, "_a_wb_addr"}, int'(a_wb), 0);
    chk({tag, "_b_wb_we"}, int'(b_we), 0);
    chk({tag, "_b_page_q"}, int'(b_pg), 0);
    chk({tag, "_b_dec_valid"}, int'(b_dv), 0);
  endtask

  task automatic clear_model();
    dq_a.delete(); dq_b.delete(); wq_a.delete(); wq_b.delete();
    inflight.delete();
    page_m[0] = 0;
    page_m[1] = 0;
  endtask

  initial begin
    reset = 1'b1;
    instr_valid = 1'b0; set_page = 1'b0; page_mode = 1'b0; rd_we = 1'b0;
    page_in = '0; rs_field = '0; rd_field = '0;
    clear_model();
    #1 reset_checks("por");
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Plain decode at page 0
    drive(1, 0, 0, 0, 1, 2, 0);
    // Sticky page 3, then a plain instruction inherits it
    drive(1, 1, 0, 3, 1, 0, 0);
    drive(1, 0, 0, 0, 2, 0, 0);
    // Sticky 1, one-shot 2, plain reverts to 1
    drive(1, 1, 0, 1, 0, 0, 0);
    drive(1, 1, 1, 2, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    // set_page without instr_valid is ignored
    drive(0, 1, 0, 2, 0, 0, 0);
    drive(1, 0, 0, 0, 1, 0, 0);
    // Back to page 0; write rd=3, dependent read, then a non-writing rd=3
    drive(1, 1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 3, 1);
    drive(1, 0, 0, 0, 3, 0, 0);
    repeat (6) drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 3, 0);
    drive(1, 0, 0, 0, 3, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);

    // Reset in the middle of a burst of writes
    drive(1, 1, 0, 1, 0, 1, 1);
    for (int i = 0; i < 5; i++) drive(1, 0, 0, 0, i, i + 1, 1);
    @(posedge clk);
    #2 reset = 1'b1;
    instr_valid = 1'b0;
    #1 reset_checks("mid");
    clear_model();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    // First instruction after release: page 0, no hazard against old writes
    drive(1, 0, 0, 0, 2, 0, 0);
    drive(1, 0, 0, 0, 3, 0, 0);

    // Random sweep
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end
    repeat (12) drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    if (dq_a.size() != 0) flag("a_dec_left", dq_a.size(), 0);
    if (dq_b.size() != 0) flag("b_dec_left", dq_b.size(), 0);
    if (wq_a.size() != 0) flag("a_wb_left", wq_a.size(), 0);
    if (wq_b.size() != 0) flag("b_wb_left", wq_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
